cnn_frame_sequencer: RTL and testbench
======================================

Name: cnn_frame_sequencer

Overview:
- Frame-level controller for the CNN inference pipeline (conv1 -> pool -> conv2 -> classifier).
- On a start request it streams one IX x IY frame from the image buffer into the stage-1 conv core under valid/ready flow control.
- It counts stage-1 and stage-2 feature-map beats and waits for the classifier result.
- It latches the recognised alpha code, pulses done, and flags errors on count violations or timeout.

Parameters:
- I_F_BW, 8, input pixel width
- IX, 28, frame width in pixels
- IY, 28, frame height in pixels
- KX, 5, conv1 kernel width
- KY, 5, conv1 kernel height
- ST2_CNT, 64, expected stage-2 output beats per frame
- TIMEOUT_CYC, 65535, maximum cycles without progress in any wait state
- A_BW, $clog2(IX*IY), image address width (derived)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_start  in  1  single-cycle frame start request
- o_busy  out  1  high in every state except IDLE, DONE and ERROR
- o_stage  out  3  current state encoding (debug)
- o_img_rd  out  1  image buffer read enable
- o_img_addr  out  A_BW  image buffer read address
- i_img_data  in  I_F_BW  read data, valid exactly 1 cycle after o_img_rd
- o_pixel_valid  out  1  pixel beat valid to conv1 core
- o_pixel  out  I_F_BW  pixel to conv1 core
- i_core_ready  in  1  conv1 core accepts the beat this cycle
- i_st1_valid  in  1  conv1 output beat
- i_st2_valid  in  1  conv2 output beat
- i_cls_valid  in  1  classifier result strobe
- i_cls_alpha  in  8  classifier ASCII code
- o_done  out  1  one-cycle pulse: frame complete
- o_alpha  out  8  latched result, held until the next successful frame
- o_error  out  1  sticky error flag

Behaviour:
- Single clock (clk); reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, all counters 0. Reset mid-frame aborts the frame immediately; the next cycle is IDLE.
- Constants:
  - NPIX = IX*IY = 784
  - ST1_CNT = (IX-KX+1)*(IY-KY+1) = 576
- States (o_stage): IDLE=0, FEED=1, WAIT1=2, WAIT2=3, CLASSIFY=4, DONE=5, ERROR=6.
- IDLE: i_start -> FEED. Clears the address, the st1/st2 counters and the timeout counter.
- FEED:
  - One-entry output register. A read is issued (o_img_rd=1, o_img_addr=next address) when the slot is empty or is being consumed (o_pixel_valid & i_core_ready) and fewer than NPIX reads have been issued.
  - Read data is loaded into o_pixel with o_pixel_valid=1 the cycle after the read.
  - o_pixel and o_pixel_valid stay stable while i_core_ready=0.
  - Sustained throughput is 1 pixel/cycle when ready stays high. First o_pixel_valid appears 2 cycles after i_start.
  - After the NPIX-th accepted beat -> WAIT1. Address wraps to 0 when leaving FEED.
- Counting: st1_cnt and st2_cnt increment on their valids in any busy state, including overlap with FEED.
- WAIT1: st1_cnt == ST1_CNT -> WAIT2. Entered with the count already met -> advance next cycle.
- WAIT2: st2_cnt == ST2_CNT -> CLASSIFY.
- CLASSIFY: i_cls_valid -> o_alpha <= i_cls_alpha, then DONE.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- Error conditions (-> ERROR, o_error=1):
  - i_st1_valid while st1_cnt == ST1_CNT
  - i_st2_valid while st2_cnt == ST2_CNT
  - i_cls_valid in any busy state other than CLASSIFY
  - timeout counter reaching TIMEOUT_CYC
- Simultaneous error and normal transition in the same cycle: error wins.
- Timeout counter resets on any accepted pixel, st1/st2 beat, or state change.
- ERROR: o_busy=0, o_alpha unchanged. i_start clears o_error and enters FEED (restart).
- i_start in any busy state is ignored.
- Counter widths: $clog2 of the expected count + 1.

Optional Feature:
- Macro CNN_SEQ_PERF_CNT_EN.
- Defined: adds output o_frame_cycles[31:0]. Counts clk cycles from i_start acceptance to the DONE cycle inclusive, updates in DONE, holds otherwise, resets to 0, saturates at 2^32-1.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package cnn_seq_pkg: state enum (3-bit), NPIX/ST1_CNT derivation functions, default IX/IY/KX/KY constants shared with cnn_top.
- Sub-module cnn_pix_feeder: address generator plus one-entry output register and ready handshake, instantiated once in FEED.
- The FSM, counters and timeout remain in the top module.

Test Plan:
- Nominal: i_start, ready=1, model returns 576 st1, 64 st2, then cls 8'h41 -> 784 beats in 784 consecutive cycles; o_done pulses once; o_alpha=8'h41; o_busy falls.
- Backpressure: ready toggles 1/0 every cycle -> o_pixel stable while stalled; addresses 0..783 delivered in order with no duplicates or drops; 1568 cycles in FEED.
- Over-count: 577th i_st1_valid -> ERROR next cycle; o_error=1; o_alpha keeps previous value; a later i_start clears o_error and restarts from address 0.
- Timeout: TIMEOUT_CYC=100, stage-2 model never responds -> ERROR exactly 100 cycles after the last st1 beat or state change.
- Reset mid-FEED at pixel 300: outputs 0 next cycle; a fresh i_start re-reads from address 0.
- Early classifier strobe: i_cls_valid during WAIT2 -> ERROR; an i_start during FEED has no effect on the address sequence.

Source files
------------

// File: rtl/cnn_seq_pkg.sv
// Shared constants, state encodings and size helpers for the CNN frame sequencer.
package cnn_seq_pkg;

    // Default frame and conv1 kernel geometry, shared with cnn_top.
    localparam int DEF_IX = 28;
    localparam int DEF_IY = 28;
    localparam int DEF_KX = 5;
    localparam int DEF_KY = 5;

    // 3-bit sequencer state; the encoding is exported on o_stage.
    typedef logic [2:0] seq_state_t;

    localparam seq_state_t S_IDLE     = 3'd0;
    localparam seq_state_t S_FEED     = 3'd1;
    localparam seq_state_t S_WAIT1    = 3'd2;
    localparam seq_state_t S_WAIT2    = 3'd3;
    localparam seq_state_t S_CLASSIFY = 3'd4;
    localparam seq_state_t S_DONE     = 3'd5;
    localparam seq_state_t S_ERROR    = 3'd6;

    // Pixels per input frame.
    function automatic int calc_npix(input int ix, input int iy);
        return ix * iy;
    endfunction

    // Valid-convolution output beats produced by conv1 for one frame.
    function automatic int calc_st1_cnt(input int ix, input int iy, input int kx, input int ky);
        return (ix - kx + 1) * (iy - ky + 1);
    endfunction

endpackage

// File: rtl/cnn_pix_feeder.sv
// Image-buffer reader feeding conv1: address generator plus a one-entry output
// slot with valid/ready handshake. Held cleared whenever i_en is low, so every
// FEED visit starts again from address 0.
module cnn_pix_feeder #(
    parameter int I_F_BW = 8,
    parameter int NPIX   = 784,
    parameter int A_BW   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_core_ready,
    input  logic [I_F_BW-1:0] i_img_data,
    output logic              o_img_rd,
    output logic [A_BW-1:0]   o_img_addr,
    output logic              o_pixel_valid,
    output logic [I_F_BW-1:0] o_pixel,
    output logic              o_accept,
    output logic              o_last
);

    localparam int RC_W = $clog2(NPIX + 1);
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(NPIX);

    logic [RC_W-1:0]   rd_cnt_q;
    logic              pend_q;
    logic              hold_v_q;
    logic [I_F_BW-1:0] hold_q;

    // The slot is either read data arriving this cycle (pend) or a captured
    // beat that the core has not yet taken (hold).
    assign o_pixel_valid = pend_q | hold_v_q;
    assign o_pixel       = hold_v_q ? hold_q : (pend_q ? i_img_data : '0);
    assign o_accept      = o_pixel_valid & i_core_ready;
    assign o_img_rd      = i_en & (rd_cnt_q != RC_MAX) & (~o_pixel_valid | o_accept);
    assign o_img_addr    = o_img_rd ? A_BW'(rd_cnt_q) : '0;
    // Once every read is issued, the single outstanding beat is the last one.
    assign o_last        = o_accept & (rd_cnt_q == RC_MAX);

    // Read counter, pending-read flag and stall capture of unaccepted data.
    always_ff @(posedge clk) begin
        if (reset || !i_en) begin
            rd_cnt_q <= '0;
            pend_q   <= 1'b0;
            hold_v_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            if (o_img_rd) begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
            end
            pend_q <= o_img_rd;
            if (pend_q && !i_core_ready) begin
                hold_q   <= i_img_data;
                hold_v_q <= 1'b1;
            end else if (o_accept) begin
                hold_v_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Frame-level controller for the conv1 -> pool -> conv2 -> classifier pipeline.
// Optional cycle counter output o_frame_cycles is enabled by CNN_SEQ_PERF_CNT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for i_start, counters cleared
// FEED     | streaming the frame from the image buffer into conv1
// WAIT1    | waiting for all conv1 output beats
// WAIT2    | waiting for all conv2 output beats
// CLASSIFY | waiting for the classifier strobe
// DONE     | one-cycle completion pulse
// ERROR    | count violation or timeout; sticky until the next i_start
module cnn_frame_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int I_F_BW      = 8,
    parameter int IX          = DEF_IX,
    parameter int IY          = DEF_IY,
    parameter int KX          = DEF_KX,
    parameter int KY          = DEF_KY,
    parameter int ST2_CNT     = 64,
    parameter int TIMEOUT_CYC = 65535,
    parameter int A_BW        = $clog2(IX * IY)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    output logic              o_busy,
    output logic [2:0]        o_stage,
    output logic              o_img_rd,
    output logic [A_BW-1:0]   o_img_addr,
    input  logic [I_F_BW-1:0] i_img_data,
    output logic              o_pixel_valid,
    output logic [I_F_BW-1:0] o_pixel,
    input  logic              i_core_ready,
    input  logic              i_st1_valid,
    input  logic              i_st2_valid,
    input  logic              i_cls_valid,
    input  logic [7:0]        i_cls_alpha,
    output logic              o_done,
    output logic [7:0]        o_alpha,
    output logic              o_error
`ifdef CNN_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       o_frame_cycles
`endif
);

    localparam int NPIX    = calc_npix(IX, IY);
    localparam int ST1_CNT = calc_st1_cnt(IX, IY, KX, KY);
    localparam int ST1_W   = $clog2(ST1_CNT) + 1;
    localparam int ST2_W   = $clog2(ST2_CNT) + 1;
    localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [ST1_W-1:0] ST1_MAX  = ST1_W'(ST1_CNT);
    localparam logic [ST2_W-1:0] ST2_MAX  = ST2_W'(ST2_CNT);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(1);

    seq_state_t       state_q;
    seq_state_t       state_nxt;
    logic [ST1_W-1:0] st1_cnt_q;
    logic [ST2_W-1:0] st2_cnt_q;
    logic [TMO_W-1:0] tmo_q;

    logic busy;
    logic pix_accept;
    logic pix_last;
    logic progress;
    logic tmo_expire;
    logic err;

    assign busy = (state_q == S_FEED) || (state_q == S_WAIT1) ||
                  (state_q == S_WAIT2) || (state_q == S_CLASSIFY);

    cnn_pix_feeder #(
        .I_F_BW (I_F_BW),
        .NPIX   (NPIX),
        .A_BW   (A_BW)
    ) u_pix_feeder (
        .clk           (clk),
        .reset         (reset),
        .i_en          (state_q == S_FEED),
        .i_core_ready  (i_core_ready),
        .i_img_data    (i_img_data),
        .o_img_rd      (o_img_rd),
        .o_img_addr    (o_img_addr),
        .o_pixel_valid (o_pixel_valid),
        .o_pixel       (o_pixel),
        .o_accept      (pix_accept),
        .o_last        (pix_last)
    );

    // The timer is a down-counter; its last cycle without progress raises the timeout.
    assign progress   = pix_accept | i_st1_valid | i_st2_valid;
    assign tmo_expire = ~progress & (tmo_q == TMO_LAST);
    assign err = busy & ((i_st1_valid & (st1_cnt_q == ST1_MAX)) |
                         (i_st2_valid & (st2_cnt_q == ST2_MAX)) |
                         (i_cls_valid & (state_q != S_CLASSIFY)) |
                         tmo_expire);

    // Next-state decode; any error overrides the normal transition.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:     if (i_start) state_nxt = S_FEED;
            S_FEED:     if (pix_last) state_nxt = S_WAIT1;
            S_WAIT1:    if (st1_cnt_q == ST1_MAX) state_nxt = S_WAIT2;
            S_WAIT2:    if (st2_cnt_q == ST2_MAX) state_nxt = S_CLASSIFY;
            S_CLASSIFY: if (i_cls_valid) state_nxt = S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            S_ERROR:    if (i_start) state_nxt = S_FEED;
            default:    state_nxt = S_IDLE;
        endcase
        if (err) begin
            state_nxt = S_ERROR;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Stage-1/stage-2 beat counters, live only while a frame is in flight.
    always_ff @(posedge clk) begin
        if (reset || !busy) begin
            st1_cnt_q <= '0;
            st2_cnt_q <= '0;
        end else begin
            if (i_st1_valid && (st1_cnt_q != ST1_MAX)) begin
                st1_cnt_q <= st1_cnt_q + 1'b1;
            end
            if (i_st2_valid && (st2_cnt_q != ST2_MAX)) begin
                st2_cnt_q <= st2_cnt_q + 1'b1;
            end
        end
    end

    // Progress timer: reloaded on any beat or state change, otherwise counts down.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
        end else if (!busy || progress || (state_nxt != state_q)) begin
            tmo_q <= TMO_LOAD;
        end else if (tmo_q != '0) begin
            tmo_q <= tmo_q - 1'b1;
        end
    end

    // Result latch, written only on a clean CLASSIFY -> DONE transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_alpha <= '0;
        end else if ((state_q == S_CLASSIFY) && (state_nxt == S_DONE)) begin
            o_alpha <= i_cls_alpha;
        end
    end

    assign o_busy  = busy;
    assign o_stage = state_q;
    assign o_done  = (state_q == S_DONE);
    assign o_error = (state_q == S_ERROR);

`ifdef CNN_SEQ_PERF_CNT_EN
    logic [31:0] run_cyc_q;

    // Frame cycle counter: the start cycle counts as 1, result published in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cyc_q      <= '0;
            o_frame_cycles <= '0;
        end else begin
            if (!busy && (state_nxt == S_FEED)) begin
                run_cyc_q <= 32'd1;
            end else if (busy && (run_cyc_q != '1)) begin
                run_cyc_q <= run_cyc_q + 1'b1;
            end
            if (state_q == S_DONE) begin
                o_frame_cycles <= (run_cyc_q == '1) ? run_cyc_q : run_cyc_q + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed, self-checking bench for cnn_frame_sequencer (timeout shortened to 100 cycles).
module tb_cnn_frame_sequencer;

    localparam int NPIX = 784;
    localparam int ST1  = 576;
    localparam int ST2  = 64;
    localparam int TMO  = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_start;
    logic       o_busy;
    logic [2:0] o_stage;
    logic       o_img_rd;
    logic [9:0] o_img_addr;
    logic [7:0] i_img_data;
    logic       o_pixel_valid;
    logic [7:0] o_pixel;
    logic       i_core_ready;
    logic       i_st1_valid;
    logic       i_st2_valid;
    logic       i_cls_valid;
    logic [7:0] i_cls_alpha;
    logic       o_done;
    logic [7:0] o_alpha;
    logic       o_error;
`ifdef CNN_SEQ_PERF_CNT_EN
    logic [31:0] o_frame_cycles;
`endif

    always #5 clk = ~clk;

    cnn_frame_sequencer #(.TIMEOUT_CYC(TMO)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .o_busy        (o_busy),
        .o_stage       (o_stage),
        .o_img_rd      (o_img_rd),
        .o_img_addr    (o_img_addr),
        .i_img_data    (i_img_data),
        .o_pixel_valid (o_pixel_valid),
        .o_pixel       (o_pixel),
        .i_core_ready  (i_core_ready),
        .i_st1_valid   (i_st1_valid),
        .i_st2_valid   (i_st2_valid),
        .i_cls_valid   (i_cls_valid),
        .i_cls_alpha   (i_cls_alpha),
        .o_done        (o_done),
        .o_alpha       (o_alpha),
        .o_error       (o_error)
`ifdef CNN_SEQ_PERF_CNT_EN
        ,
        .o_frame_cycles(o_frame_cycles)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix_of(input int a);
        return 8'(a * 37 + 5) ^ 8'(a >> 8);
    endfunction

    // Image buffer: synchronous read, data valid the cycle after o_img_rd.
    always @(posedge clk) begin
        if (o_img_rd) i_img_data <= pix_of(int'(o_img_addr));
    end

    // Scoreboard state shared with the monitor.
    logic [7:0] pix_q[$];
    int         rd_exp   = 0;
    int         beats    = 0;
    int         first_t  = 0;
    int         last_t   = 0;
    int         cyc_no   = 0;
    int         done_cnt = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_pix;

    // Monitor sampled on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        logic [7:0] exp_pix;
        cyc_no++;
        if (o_done) done_cnt++;
        if (!reset) begin
            if (prev_stall)
                check("stall_stable", 32'({o_pixel_valid, o_pixel}), 32'({1'b1, prev_pix}));
            if (o_img_rd) begin
                check("rd_addr", 32'(o_img_addr), 32'(rd_exp));
                rd_exp++;
            end
            if (o_pixel_valid && i_core_ready) begin
                check("beat_in_range", 32'(beats < NPIX), 32'd1);
                if (pix_q.size() > 0) begin
                    exp_pix = pix_q.pop_front();
                    check("pixel", 32'(o_pixel), 32'(exp_pix));
                end
                beats++;
                if (beats == 1) first_t = cyc_no;
                last_t = cyc_no;
            end
            prev_stall = o_pixel_valid && !i_core_ready;
            prev_pix   = o_pixel;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_start();
        pix_q.delete();
        for (int i = 0; i < NPIX; i++) pix_q.push_back(pix_of(i));
        rd_exp  = 0;
        beats   = 0;
        first_t = 0;
        last_t  = 0;
    endtask

    task automatic check_zero_outs(input string tag);
        check({tag, "_ctl"}, 32'({o_busy, o_stage, o_img_rd, o_img_addr, o_pixel_valid, o_done, o_error}), 32'd0);
        check({tag, "_dat"}, 32'({o_pixel, o_alpha}), 32'd0);
    endtask

    // Starts a frame and feeds it; stop_at > 0 leaves FEED early after that many beats.
    task automatic feed(input bit bp, input bit st1_ovl, input bit poke_start, input int stop_at);
        int n;
        int s1;
        sb_start();
        i_core_ready = 1'b1;
        i_start = 1'b1;
        cyc();
        i_start = 1'b0;
        check("start_stage", 32'(o_stage), 32'd1);
        check("start_err_clr", 32'(o_error), 32'd0);
        check("first_rd", 32'({o_img_rd, o_pixel_valid}), 32'b10);
        n  = 0;
        s1 = 0;
        while (o_stage == 3'd1 && n < 5000 && !(stop_at > 0 && beats >= stop_at)) begin
            if (bp) i_core_ready = ~i_core_ready;
            i_st1_valid = st1_ovl && (s1 < ST1);
            if (i_st1_valid) s1++;
            i_start = poke_start && (n == 100);
            cyc();
            n++;
            if (n == 1) check("first_valid", 32'(o_pixel_valid), 32'd1);
        end
        i_start      = 1'b0;
        i_st1_valid  = 1'b0;
        i_core_ready = 1'b1;
        if (stop_at == 0) begin
            check("feed_bound", 32'(n < 5000), 32'd1);
            check("beats", 32'(beats), 32'(NPIX));
            check("pix_left", 32'(pix_q.size()), 32'd0);
            check("beat_span", 32'(last_t - first_t + 1), bp ? 32'd1567 : 32'd784);
        end
    endtask

    task automatic send_st1(input int cnt);
        repeat (cnt) begin
            i_st1_valid = 1'b1;
            cyc();
        end
        i_st1_valid = 1'b0;
    endtask

    task automatic finish_frame(input bit st1_done, input logic [7:0] alpha);
        int d0;
        d0 = done_cnt;
        check("wait1_stage", 32'(o_stage), 32'd2);
        if (!st1_done) send_st1(ST1);
        cyc();
        check("wait2_stage", 32'(o_stage), 32'd3);
        repeat (ST2) begin
            i_st2_valid = 1'b1;
            cyc();
        end
        i_st2_valid = 1'b0;
        check("wait2_hold", 32'(o_stage), 32'd3);
        cyc();
        check("classify_stage", 32'(o_stage), 32'd4);
        i_cls_alpha = alpha;
        i_cls_valid = 1'b1;
        cyc();
        i_cls_valid = 1'b0;
        check("done_state", 32'({o_stage, o_done, o_busy, o_error}), 32'({3'd5, 1'b1, 1'b0, 1'b0}));
        check("done_alpha", 32'(o_alpha), 32'(alpha));
        cyc();
        check("idle_after_done", 32'({o_stage, o_done, o_busy}), 32'd0);
        check("alpha_held", 32'(o_alpha), 32'(alpha));
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int n;
        int d0;
        reset        = 1'b1;
        i_start      = 1'b0;
        i_core_ready = 1'b0;
        i_st1_valid  = 1'b0;
        i_st2_valid  = 1'b0;
        i_cls_valid  = 1'b0;
        i_cls_alpha  = 8'h00;
        repeat (3) cyc();
        check_zero_outs("reset");
        reset = 1'b0;
        cyc();

        // Nominal frame, ready always high.
        feed(1'b0, 1'b0, 1'b0, 0);
        finish_frame(1'b0, 8'h41);

        // Backpressure, conv1 beats overlapping FEED, stray i_start mid-FEED.
        feed(1'b1, 1'b1, 1'b1, 0);
        finish_frame(1'b1, 8'h42);

        // 577th conv1 beat.
        feed(1'b0, 1'b0, 1'b0, 0);
        check("ovc_wait1", 32'(o_stage), 32'd2);
        send_st1(ST1 + 1);
        check("ovc_state", 32'({o_stage, o_error, o_busy}), 32'({3'd6, 1'b1, 1'b0}));
        check("ovc_alpha", 32'(o_alpha), 32'h42);
        cyc();
        check("ovc_sticky", 32'(o_error), 32'd1);
        feed(1'b0, 1'b0, 1'b0, 0);
        finish_frame(1'b0, 8'h43);

        // Stage-2 never answers.
        feed(1'b0, 1'b0, 1'b0, 0);
        send_st1(ST1);
        cyc();
        check("tmo_wait2", 32'(o_stage), 32'd3);
        n = 0;
        while (o_stage == 3'd3 && n < 300) begin
            cyc();
            n++;
        end
        check("tmo_cycles", 32'(n), 32'(TMO));
        check("tmo_state", 32'({o_stage, o_error}), 32'({3'd6, 1'b1}));
        check("tmo_alpha", 32'(o_alpha), 32'h43);

        // Reset in the middle of FEED.
        feed(1'b0, 1'b0, 1'b0, 300);
        check("mid_beats", 32'(beats), 32'd300);
        reset = 1'b1;
        i_core_ready = 1'b0;
        cyc();
        reset = 1'b0;
        i_core_ready = 1'b1;
        check_zero_outs("reset_mid");
        feed(1'b0, 1'b0, 1'b0, 0);
        finish_frame(1'b0, 8'h44);

        // Classifier strobe while still in WAIT2.
        d0 = done_cnt;
        feed(1'b0, 1'b0, 1'b0, 0);
        send_st1(ST1);
        cyc();
        check("early_wait2", 32'(o_stage), 32'd3);
        i_cls_alpha = 8'h55;
        i_cls_valid = 1'b1;
        cyc();
        i_cls_valid = 1'b0;
        check("early_state", 32'({o_stage, o_error, o_busy}), 32'({3'd6, 1'b1, 1'b0}));
        check("early_alpha", 32'(o_alpha), 32'h44);
        check("early_no_done", 32'(done_cnt - d0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
